// File: rtl/pin_pkg.sv
// pin_pkg: shared types and constants for the lock's PIN datapath.
//   digit_t        - one BCD digit
//   DIGIT_INVALID  - filler value for an empty or scrubbed digit slot
//   DIGIT_MAX      - largest legal digit value
//   err_t          - error qualifier reported by master_pin_ctrl
//   pinPac_t       - assembled 4-digit PIN plus its valid flag, as exchanged
//                    with the keypad assembler
package pin_pkg;

  typedef logic [3:0] digit_t;

  localparam digit_t DIGIT_INVALID = 4'hF;
  localparam digit_t DIGIT_MAX     = 4'd9;

  typedef enum logic [2:0] {
    ERR_NONE     = 3'd0,
    ERR_INVALID  = 3'd1,
    ERR_MISMATCH = 3'd2,
    ERR_TIMEOUT  = 3'd3,
    ERR_SAME     = 3'd4
  } err_t;

  typedef struct packed {
    logic             valid;
    digit_t [3:0]     digits;
  } pinPac_t;

  function automatic logic digit_is_legal(digit_t d);
    return d <= DIGIT_MAX;
  endfunction

endpackage

// File: rtl/pin_timeout_counter.sv
// pin_timeout_counter: idle-cycle counter for the master-PIN wait states.
//   clk, rst  - clock, asynchronous active-low reset
//   clear     - restart counting from zero (wins over enable)
//   enable    - count this cycle
//   expired   - combinational: enabled while the count already sits at
//               TIMEOUT_CYCLES-1, i.e. this edge is the TIMEOUT_CYCLES-th idle edge
module pin_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_reg;

  assign expired = enable && (count_reg == LAST);

  // Restart after expiry so the counter never wraps through stale values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
    end else if (clear || expired) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= count_reg + CW'(1);
    end
  end

endmodule

// File: rtl/master_pin_ctrl.sv
// master_pin_ctrl: two-entry master-PIN change controller.
//   A change_req opens the change; the new PIN must be entered twice
//   (WAIT_FIRST, WAIT_CONFIRM) before it is committed to master_digits.
// Ports:
//   clk, rst (async active-low), change_req, abort, pin_valid, pin_digits
//   master_digits, master_valid, busy, done, error, err_code
// Build option: define MASTER_PIN_REJECT_SAME_EN to reject a new PIN equal
//   to the current master PIN with ERR_SAME.
module master_pin_ctrl
  import pin_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 change_req,
  input  logic                 abort,
  input  logic                 pin_valid,
  input  digit_t [DIGITS-1:0]  pin_digits,
  output digit_t [DIGITS-1:0]  master_digits,
  output logic                 master_valid,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output err_t                 err_code
);

  localparam logic [1:0] IDLE         = 2'd0;
  localparam logic [1:0] WAIT_FIRST   = 2'd1;
  localparam logic [1:0] WAIT_CONFIRM = 2'd2;

  localparam digit_t [DIGITS-1:0] PIN_BLANK = {DIGITS{DIGIT_INVALID}};

  logic [1:0]          state_reg, state_next;
  digit_t [DIGITS-1:0] shadow_reg, shadow_next;
  digit_t [DIGITS-1:0] master_reg, master_next;
  logic                master_valid_reg, master_valid_next;
  logic                busy_reg;
  logic                done_reg, done_next;
  logic                error_reg, error_next;
  err_t                err_code_reg, err_code_next;

  logic                in_wait;
  logic                timer_clear, timer_enable, timer_expired;
  logic [DIGITS-1:0]   digit_ok;
  logic                pin_ok;
  logic                pin_eq_shadow;
`ifdef MASTER_PIN_REJECT_SAME_EN
  logic                pin_eq_master;
  assign pin_eq_master = (pin_digits == master_reg);
`endif

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit_check
    assign digit_ok[gi] = digit_is_legal(pin_digits[gi]);
  end

  assign pin_ok        = &digit_ok;
  assign pin_eq_shadow = (pin_digits == shadow_reg);
  assign in_wait       = (state_reg != IDLE);

  // Any accepted strobe or abort restarts the idle window.
  assign timer_clear  = !in_wait || pin_valid || abort;
  assign timer_enable = in_wait && !pin_valid && !abort;

  pin_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear),
    .enable (timer_enable),
    .expired(timer_expired)
  );

  always_comb begin
    state_next        = state_reg;
    shadow_next       = shadow_reg;
    master_next       = master_reg;
    master_valid_next = master_valid_reg;
    done_next         = 1'b0;
    error_next        = 1'b0;
    err_code_next     = err_code_reg;

    case (state_reg)
      IDLE: begin
        if (change_req) state_next = WAIT_FIRST;
      end
      WAIT_FIRST: begin
        if (abort) begin
          state_next = IDLE;
        end else if (pin_valid) begin
          if (!pin_ok) begin
            error_next    = 1'b1;
            err_code_next = ERR_INVALID;
`ifdef MASTER_PIN_REJECT_SAME_EN
          end else if (master_valid_reg && pin_eq_master) begin
            error_next    = 1'b1;
            err_code_next = ERR_SAME;
`endif
          end else begin
            shadow_next = pin_digits;
            state_next  = WAIT_CONFIRM;
          end
        end else if (timer_expired) begin
          error_next    = 1'b1;
          err_code_next = ERR_TIMEOUT;
          state_next    = IDLE;
        end
      end
      WAIT_CONFIRM: begin
        if (abort) begin
          state_next = IDLE;
        end else if (pin_valid) begin
          // The shadow only ever holds a legal PIN, so an illegal entry
          // can never compare equal and falls into the mismatch path.
          if (pin_eq_shadow) begin
            master_next       = shadow_reg;
            master_valid_next = 1'b1;
            done_next         = 1'b1;
          end else begin
            error_next    = 1'b1;
            err_code_next = ERR_MISMATCH;
          end
          state_next = IDLE;
        end else if (timer_expired) begin
          error_next    = 1'b1;
          err_code_next = ERR_TIMEOUT;
          state_next    = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    // Never leave a half-entered PIN lying around once the change ends.
    if (state_next == IDLE) shadow_next = PIN_BLANK;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg        <= IDLE;
      shadow_reg       <= PIN_BLANK;
      master_reg       <= PIN_BLANK;
      master_valid_reg <= 1'b0;
      busy_reg         <= 1'b0;
      done_reg         <= 1'b0;
      error_reg        <= 1'b0;
      err_code_reg     <= ERR_NONE;
    end else begin
      state_reg        <= state_next;
      shadow_reg       <= shadow_next;
      master_reg       <= master_next;
      master_valid_reg <= master_valid_next;
      busy_reg         <= (state_next != IDLE);
      done_reg         <= done_next;
      error_reg        <= error_next;
      err_code_reg     <= err_code_next;
    end
  end

  assign master_digits = master_reg;
  assign master_valid  = master_valid_reg;
  assign busy          = busy_reg;
  assign done          = done_reg;
  assign error         = error_reg;
  assign err_code      = err_code_reg;

endmodule

// File: tb/tb_master_pin_ctrl.sv
// tb_master_pin_ctrl: directed bench for master_pin_ctrl (DIGITS=4,
// TIMEOUT_CYCLES=8). A transaction-level model tracks the change procedure
// and is compared against the DUT on every falling edge; literal checks at
// key points pin the model. Honours MASTER_PIN_REJECT_SAME_EN.
module tb_master_pin_ctrl;
  import pin_pkg::*;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        change_req = 1'b0;
  logic        abort = 1'b0;
  logic        pin_valid = 1'b0;
  logic [15:0] pin_digits = 16'h0000;
  logic [15:0] master_digits;
  logic        master_valid, busy, done, error;
  err_t        err_code;

  int n_vec = 0;
  int n_err = 0;

  master_pin_ctrl #(.DIGITS(4), .TIMEOUT_CYCLES(T)) dut (
    .clk          (clk),
    .rst          (rst),
    .change_req   (change_req),
    .abort        (abort),
    .pin_valid    (pin_valid),
    .pin_digits   (pin_digits),
    .master_digits(master_digits),
    .master_valid (master_valid),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .err_code     (err_code)
  );

  always #5 clk = ~clk;

  // ---------------- model: the change procedure as a sequence of phases
  typedef struct {
    int          phase;    // 0 no change open, 1 expecting new PIN, 2 expecting repeat
    logic [15:0] shadow;
    logic [15:0] master;
    logic        mvalid;
    logic        busy;
    logic        done;
    logic        error;
    logic [2:0]  code;
    int          waited;   // idle edges seen since entry / last strobe
  } mdl_t;

  mdl_t m;

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r.phase = 0; r.shadow = 16'hFFFF; r.master = 16'hFFFF; r.mvalid = 0;
    r.busy = 0; r.done = 0; r.error = 0; r.code = 3'd0; r.waited = 0;
    return r;
  endfunction

  function automatic bit all_bcd(logic [15:0] p);
    for (int i = 0; i < 4; i++) if (p[i*4 +: 4] > 4'd9) return 0;
    return 1;
  endfunction

  function automatic void fail_with(ref mdl_t n, input logic [2:0] c, input bit leave);
    n.error = 1; n.code = c; n.waited = 0;
    if (leave) n.phase = 0;
  endfunction

  function automatic mdl_t mdl_step(mdl_t cur, bit cr, bit ab, bit pv, logic [15:0] pd);
    mdl_t n = cur;
    bit same_rej;
    n.done = 0; n.error = 0;
`ifdef MASTER_PIN_REJECT_SAME_EN
    same_rej = cur.mvalid && (pd == cur.master);
`else
    same_rej = 0;
`endif
    if (cur.phase == 0) begin
      if (cr) begin n.phase = 1; n.waited = 0; end
    end else if (ab) begin
      n.phase = 0;
    end else if (pv) begin
      if (cur.phase == 1) begin
        if (!all_bcd(pd))   fail_with(n, 3'd1, 0);
        else if (same_rej)  fail_with(n, 3'd4, 0);
        else begin n.shadow = pd; n.phase = 2; n.waited = 0; end
      end else begin
        if (pd == cur.shadow) begin
          n.master = cur.shadow; n.mvalid = 1; n.done = 1; n.phase = 0;
        end else fail_with(n, 3'd2, 1);
      end
    end else begin
      n.waited = cur.waited + 1;
      if (n.waited == T) fail_with(n, 3'd3, 1);
    end
    if (n.phase == 0) begin n.shadow = 16'hFFFF; n.waited = 0; end
    n.busy = (n.phase != 0);
    return n;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) m <= mdl_reset();
    else      m <= mdl_step(m, change_req, abort, pin_valid, pin_digits);
  end

  // ---------------- checking
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("busy",          16'(busy),         16'(m.busy));
    check("done",          16'(done),         16'(m.done));
    check("error",         16'(error),        16'(m.error));
    check("err_code",      16'(err_code),     16'(m.code));
    check("master_digits", master_digits,     m.master);
    check("master_valid",  16'(master_valid), 16'(m.mvalid));
    check("shadow",        dut.shadow_reg,    m.shadow);
  end

  // ---------------- stimulus
  task automatic step(input bit cr, input bit ab, input bit pv, input logic [15:0] pd);
    @(negedge clk);
    change_req = cr; abort = ab; pin_valid = pv; pin_digits = pd;
    if (cr || ab || pv)
      $display("txn t=%0t change_req=%0b abort=%0b pin_valid=%0b pin=%h", $time, cr, ab, pv, pd);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 16'h0000);
  endtask

  initial begin
    // reset
    repeat (3) @(negedge clk);
    check("rst master",   master_digits, 16'hFFFF);
    check("rst err_code", 16'(err_code), 16'h0000);
    rst = 1'b1;
    idle(2);

    // commit 1234 with back-to-back strobes
    step(1, 0, 0, 16'h0000);
    step(0, 0, 1, 16'h1234);
    step(0, 0, 1, 16'h1234);
    idle(1);
    check("commit done",   16'(done),         16'h0001);
    check("commit master", master_digits,     16'h1234);
    check("commit mvalid", 16'(master_valid), 16'h0001);
    check("commit busy",   16'(busy),         16'h0000);

    // mismatch 5678 / 5679
    step(1, 0, 0, 16'h0000);
    step(0, 0, 1, 16'h5678);
    step(0, 0, 1, 16'h5679);
    idle(1);
    check("mism error",  16'(error),     16'h0001);
    check("mism code",   16'(err_code),  16'h0002);
    check("mism master", master_digits,  16'h1234);

    // invalid digit, stray change_req while busy, then 4321 twice
    step(1, 0, 0, 16'h0000);
    step(0, 0, 1, 16'h1A34);
    idle(1);
    check("inval code", 16'(err_code), 16'h0001);
    check("inval busy", 16'(busy),     16'h0001);
    step(1, 0, 0, 16'h0000);
    step(0, 0, 1, 16'h4321);
    step(0, 0, 1, 16'h4321);
    idle(1);
    check("4321 master", master_digits, 16'h4321);

    // timeout: error exactly T edges after entry
    step(1, 0, 0, 16'h0000);
    idle(T);
    check("to pre busy",  16'(busy),  16'h0001);
    check("to pre error", 16'(error), 16'h0000);
    idle(1);
    check("to error", 16'(error),    16'h0001);
    check("to code",  16'(err_code), 16'h0003);
    check("to busy",  16'(busy),     16'h0000);

    // strobe on the 7th edge after entry is still accepted
    step(1, 0, 0, 16'h0000);
    idle(T - 2);
    step(0, 0, 1, 16'h5555);
    idle(1);
    check("late busy",  16'(busy),  16'h0001);
    check("late error", 16'(error), 16'h0000);
    step(0, 0, 1, 16'h5555);
    idle(1);
    check("late master", master_digits, 16'h5555);

    // abort together with the confirming strobe: silent return
    step(1, 0, 0, 16'h0000);
    step(0, 0, 1, 16'h1111);
    step(0, 1, 1, 16'h1111);
    idle(1);
    check("abort busy",   16'(busy),       16'h0000);
    check("abort done",   16'(done),       16'h0000);
    check("abort error",  16'(error),      16'h0000);
    check("abort code",   16'(err_code),   16'h0003);
    check("abort shadow", dut.shadow_reg,  16'hFFFF);
    check("abort master", master_digits,   16'h5555);

    // abort and stray strobe while idle do nothing
    step(0, 1, 1, 16'h7777);
    idle(1);
    check("idle abort busy", 16'(busy), 16'h0000);

    // same PIN as current master
    step(1, 0, 0, 16'h0000);
    step(0, 0, 1, 16'h5555);
    idle(1);
`ifdef MASTER_PIN_REJECT_SAME_EN
    check("same code", 16'(err_code), 16'h0004);
    check("same busy", 16'(busy),     16'h0001);
    step(0, 1, 0, 16'h0000);
    idle(1);
`else
    check("same error", 16'(error), 16'h0000);
    step(0, 0, 1, 16'h5555);
    idle(1);
    check("same done", 16'(done), 16'h0001);
`endif

    // asynchronous reset in the middle of a change
    step(1, 0, 0, 16'h0000);
    step(0, 0, 1, 16'h2222);
    idle(1);
    #2 rst = 1'b0;
    #1;
    check("arst busy",   16'(busy),         16'h0000);
    check("arst master", master_digits,     16'hFFFF);
    check("arst mvalid", 16'(master_valid), 16'h0000);
    check("arst code",   16'(err_code),     16'h0000);
    @(negedge clk);
    rst = 1'b1;
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/master_pin_ctrl.md
# master_pin_ctrl

Parametrised master-PIN update controller for the digital lock. On an explicit change request it accepts a new PIN and requires the same PIN to be entered a second time before committing it. It supports configurable PIN length, a per-step inactivity timeout, abort, and error reporting. It sits between the keypad PIN assembler, which emits a PIN plus a one-cycle confirm (`*`) strobe, and the comparator block that consumes the stored master PIN.

## Interface
Parameters:
- `DIGITS`, 4: number of BCD digits in the PIN (≥1).
- `TIMEOUT_CYCLES`, 1000: idle cycles allowed in each wait state before abandoning (≥2).

Ports:
- `clk`, in, 1: single clock; all logic rising-edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `change_req`, in, 1: one-cycle request to start a master-PIN change.
- `abort`, in, 1: cancel an in-progress change.
- `pin_valid`, in, 1: one-cycle confirm strobe from the keypad assembler.
- `pin_digits`, in, `DIGITS`×4: entered PIN as a packed `digit_t` array; index `DIGITS-1` is the first digit.
- `master_digits`, out, `DIGITS`×4: committed master PIN.
- `master_valid`, out, 1: high once any master PIN has been committed since reset.
- `busy`, out, 1: high in `WAIT_FIRST` and `WAIT_CONFIRM`.
- `done`, out, 1: one-cycle pulse when a new master PIN is committed.
- `error`, out, 1: one-cycle pulse when a change attempt fails.
- `err_code`, out, 3: `err_t` qualifying `error`; holds the last code until the next `error` pulse or reset.

## Operation
- Reset values: state `IDLE`, every `master_digits` digit 4'hF, `master_valid` 0, `busy` 0, `done` 0, `error` 0, `err_code` `ERR_NONE` (0), shadow register all 4'hF, timeout counter 0.
- A PIN is valid when every digit is ≤ 9.
- FSM states:
  - `IDLE`: on `change_req`, go to `WAIT_FIRST` and clear the counter. `pin_valid` is ignored here.
  - `WAIT_FIRST`:
    - `pin_valid` with a valid PIN: capture it into the shadow register, go to `WAIT_CONFIRM`, clear the counter.
    - `pin_valid` with an invalid PIN: error `ERR_INVALID` (1), stay in `WAIT_FIRST`, clear the counter.
  - `WAIT_CONFIRM`:
    - `pin_valid` equal to the shadow register: commit the shadow to `master_digits`, set `master_valid`, pulse `done`, go to `IDLE`.
    - `pin_valid` not equal to the shadow register, including invalid digits: error `ERR_MISMATCH` (2), go to `IDLE`.
- Timeout: the counter increments on every cycle in a wait state without `pin_valid`. When it reaches `TIMEOUT_CYCLES-1`: error `ERR_TIMEOUT` (3), go to `IDLE`.
- Abort: `abort` while `busy` goes to `IDLE` silently (no `error`). `abort` in `IDLE` has no effect.
- Every return to `IDLE` scrubs the shadow register to all 4'hF.
- Priority when events coincide: `abort` > `pin_valid` > timeout. `change_req` while `busy` is ignored.
- `master_digits` and `master_valid` change only on commit or reset. A failed attempt never alters them.

## Timing
- All outputs are registered. `done`, `error`, and the `err_code` update appear in the cycle after the edge that samples the triggering `pin_valid`, timeout, or abort condition. Latency is 1 cycle.
- `master_digits` updates on the same edge that raises `done`.
- `busy` rises the cycle after `change_req` is sampled and falls together with `done` or `error`.
- Timeout fires exactly `TIMEOUT_CYCLES` cycles after entry into a wait state, or after the last accepted `pin_valid`.
- Reset mid-change returns to the reset values immediately (asynchronous assertion). The previous master PIN is lost.
- Back-to-back `pin_valid` on consecutive cycles is legal: `WAIT_FIRST` → `WAIT_CONFIRM` → commit.

## Configuration
- `MASTER_PIN_REJECT_SAME_EN` defined:
  - In `WAIT_FIRST`, a valid PIN equal to the current `master_digits` while `master_valid` is 1 raises `ERR_SAME` (4) and stays in `WAIT_FIRST`.
- `MASTER_PIN_REJECT_SAME_EN` undefined:
  - Such a PIN is accepted like any other.
  - `ERR_SAME` is never produced.

## Structure
- Shared package `pin_pkg`:
  - `digit_t` (logic [3:0]).
  - `DIGIT_INVALID` = 4'hF.
  - `DIGIT_MAX` = 9.
  - `err_t` enum, 3-bit: `ERR_NONE`, `ERR_INVALID`, `ERR_MISMATCH`, `ERR_TIMEOUT`, `ERR_SAME`.
  - The existing `pinPac_t` struct.
- Sub-module `pin_timeout_counter`: parameter `TIMEOUT_CYCLES`; inputs `clear` and `enable`; output `expired`. The FSM and the digit-validity/compare logic stay in `master_pin_ctrl`.

## Test plan
- Reset, then `change_req`; PIN 1-2-3-4 → `WAIT_CONFIRM`; 1-2-3-4 again → `done` 1 cycle later, `master_digits` = 1234, `master_valid` = 1.
- After committing 1234: change to 5-6-7-8 then 5-6-7-9 → `error`, `err_code` = 2; `master_digits` remains 1234.
- In `WAIT_FIRST`, PIN 1-A-3-4 → `err_code` = 1, state stays `WAIT_FIRST`; then 4-3-2-1 twice → commit 4321.
- `TIMEOUT_CYCLES` = 8: `change_req` with no `pin_valid` → `error` with `err_code` = 3 exactly 8 cycles after entry; `busy` falls. In a second run, `pin_valid` on cycle 7 is accepted.
- `abort` and `pin_valid` in the same cycle during `WAIT_CONFIRM` → `IDLE`, no `done`, no `error`, shadow reads all F; `rst` low mid-change → all outputs at reset values.
- `MASTER_PIN_REJECT_SAME_EN` defined, master = 1234: entering 1-2-3-4 → `err_code` = 4. Undefined: the same entry is accepted.
